// File: rtl/i2s_rx_deserializer.sv
// i2s_rx_deserializer
// Deserializes an I2S ADC stream (bit clock, channel clock, serial data, all
// asynchronous to clk_100) into parallel left/right samples.
//
// Ports
//   clk_100       system clock
//   reset         synchronous, active-high; clears everything, state -> HUNT
//   i2s_bclk      asynchronous bit clock (64 bclk per frame)
//   i2s_lr        asynchronous channel clock, 0 = left, 1 = right
//   i2s_sdata     asynchronous serial data, MSB first
//   left_sample   last complete left word
//   right_sample  last complete right word
//   left_16       top 16 bits of left_sample
//   frame_valid   one-cycle pulse when a stereo pair is committed
//   short_err     one-cycle pulse when a slot ended with too few bits
//   locked        high once the first channel boundary has been seen
//
// state | meaning
// HUNT  | waiting for the first lr change; data ignored
// RECV  | aligned to slots; shifting bits and committing words on boundaries

module i2s_rx_deserializer #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk_100,
  input  logic                    reset,
  input  logic                    i2s_bclk,
  input  logic                    i2s_lr,
  input  logic                    i2s_sdata,
  output logic [SAMPLE_WIDTH-1:0] left_sample,
  output logic [SAMPLE_WIDTH-1:0] right_sample,
  output logic [15:0]             left_16,
  output logic                    frame_valid,
  output logic                    short_err,
  output logic                    locked
);

  localparam int CW = $clog2(SAMPLE_WIDTH + 1);

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] bclk_sync_q, lr_sync_q, sd_sync_q;
  logic                   bclk_dly_q;
  logic                   bclk_s, lr_s, sd_s, rise;

  state_e                 state_q, state_d;
  logic                   lr_last_q, lr_last_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d;
  logic [SAMPLE_WIDTH-1:0] right_q, right_d;
  logic                   left_ok_q, left_ok_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   short_err_q, short_err_d;
  logic                   locked_q, locked_d;

  // All three inputs share the same depth so lr_s/sd_s are coherent with the
  // bclk edge seen at the end of the pipeline.
  always_ff @(posedge clk_100) begin
    if (reset) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      bclk_dly_q  <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], i2s_bclk};
      lr_sync_q   <= {lr_sync_q[SYNC_STAGES-2:0], i2s_lr};
      sd_sync_q   <= {sd_sync_q[SYNC_STAGES-2:0], i2s_sdata};
      bclk_dly_q  <= bclk_s;
    end
  end

  assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
  assign lr_s   = lr_sync_q[SYNC_STAGES-1];
  assign sd_s   = sd_sync_q[SYNC_STAGES-1];
  assign rise   = bclk_s & ~bclk_dly_q;

  always_ff @(posedge clk_100) begin
    if (reset) begin
      state_q       <= HUNT;
      lr_last_q     <= 1'b0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      left_q        <= '0;
      right_q       <= '0;
      left_ok_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      short_err_q   <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      lr_last_q     <= lr_last_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      left_q        <= left_d;
      right_q       <= right_d;
      left_ok_q     <= left_ok_d;
      frame_valid_q <= frame_valid_d;
      short_err_q   <= short_err_d;
      locked_q      <= locked_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lr_last_d     = lr_last_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    left_d        = left_q;
    right_d       = right_q;
    left_ok_d     = left_ok_q;
    locked_d      = locked_q;
    frame_valid_d = 1'b0;
    short_err_d   = 1'b0;

    if (rise) begin
      lr_last_d = lr_s;
      case (state_q)
        HUNT: begin
          if (lr_s != lr_last_q) begin
            state_d   = RECV;
            locked_d  = 1'b1;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        RECV: begin
          if (lr_s != lr_last_q) begin
            // Boundary rise is the one-bit-delay slot: commit the slot that
            // just ended (channel = lr_last_q) and drop this rise's data.
            bit_cnt_d = '0;
            shift_d   = '0;
            if (bit_cnt_q == CW'(SAMPLE_WIDTH)) begin
              if (!lr_last_q) begin
                left_d    = shift_q;
                left_ok_d = 1'b1;
              end else begin
                right_d       = shift_q;
                frame_valid_d = left_ok_q;
                left_ok_d     = 1'b0;
              end
            end else begin
              short_err_d = 1'b1;
              left_ok_d   = 1'b0;
            end
          end else if (bit_cnt_q < CW'(SAMPLE_WIDTH)) begin
            shift_d   = {shift_q[SAMPLE_WIDTH-2:0], sd_s};
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign left_sample  = left_q;
  assign right_sample = right_q;
  assign left_16      = left_q[SAMPLE_WIDTH-1 -: 16];
  assign frame_valid  = frame_valid_q;
  assign short_err    = short_err_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench for i2s_rx_deserializer: drives I2S frames built from
// hand-chosen words and compares the captured samples and pulse counts.

module tb_i2s_rx_deserializer;

  localparam int H = 4;  // clk_100 cycles per bclk half period

  logic        clk_100 = 1'b0;
  logic        reset   = 1'b1;
  logic        i2s_bclk = 1'b0;
  logic        i2s_lr   = 1'b0;
  logic        i2s_sdata = 1'b0;
  logic [23:0] left_sample, right_sample;
  logic [15:0] left_16;
  logic        frame_valid, short_err, locked;

  i2s_rx_deserializer #(.SAMPLE_WIDTH(24), .SYNC_STAGES(2)) dut (
    .clk_100      (clk_100),
    .reset        (reset),
    .i2s_bclk     (i2s_bclk),
    .i2s_lr       (i2s_lr),
    .i2s_sdata    (i2s_sdata),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .left_16      (left_16),
    .frame_valid  (frame_valid),
    .short_err    (short_err),
    .locked       (locked)
  );

  always #5 clk_100 = ~clk_100;

  int vectors = 0;
  int miscompares = 0;

  int          fv_cnt = 0, se_cnt = 0;
  logic [23:0] fv_l[$], fv_r[$];
  logic        fv_prev = 1'b0, se_prev = 1'b0;
  logic        overlap = 1'b0, wide = 1'b0;

  int tail_pending = 0;
  int stall_bit = -1;
  int fv_base, se_base;

  always @(negedge clk_100) begin
    if (frame_valid) begin
      fv_cnt++;
      fv_l.push_back(left_sample);
      fv_r.push_back(right_sample);
    end
    if (short_err) se_cnt++;
    if (frame_valid && short_err) overlap = 1'b1;
    if ((frame_valid && fv_prev) || (short_err && se_prev)) wide = 1'b1;
    fv_prev = frame_valid;
    se_prev = short_err;
  end

  initial begin
    #1_500_000;
    $display("FAIL timeout: got=still running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bclk_bit(input logic lr, input logic sd);
    i2s_bclk  = 1'b0;
    i2s_lr    = lr;
    i2s_sdata = sd;
    repeat (H) @(negedge clk_100);
    i2s_bclk = 1'b1;
    repeat (H) @(negedge clk_100);
  endtask

  // Bit 0 of a slot is the delay bit (lr already switched); it carries a 1
  // so a receiver that wrongly captures it corrupts the word.
  task automatic send_slot(input logic lr, input logic [23:0] data, input int total);
    int first;
    logic sd;
    first = (lr == 1'b0 && tail_pending != 0) ? 1 : 0;
    tail_pending = 0;
    for (int b = first; b < total; b++) begin
      if (b == 0)       sd = 1'b1;
      else if (b <= 24) sd = data[24-b];
      else              sd = 1'b0;
      bclk_bit(lr, sd);
      if (b == stall_bit) repeat (10000) @(negedge clk_100);
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int total);
    send_slot(1'b0, l, total);
    send_slot(1'b1, r, total);
  endtask

  // Delay bit of the next left slot: closes the pending right slot.
  task automatic tail();
    bclk_bit(1'b0, 1'b1);
    tail_pending = 1;
    repeat (8) @(negedge clk_100);
  endtask

  task automatic snap();
    fv_base = fv_cnt;
    se_base = se_cnt;
  endtask

  task automatic chk_pair(input string tag, input int idx, input logic [23:0] l, input logic [23:0] r);
    if (idx < fv_l.size()) begin
      chk({tag, "_l"}, {8'h0, fv_l[idx]}, {8'h0, l});
      chk({tag, "_r"}, {8'h0, fv_r[idx]}, {8'h0, r});
    end else begin
      chk({tag, "_missing"}, idx, fv_l.size());
    end
  endtask

  initial begin
    repeat (5) @(negedge clk_100);
    reset = 1'b0;
    repeat (3) @(negedge clk_100);
    chk("rst_left", {8'h0, left_sample}, 32'h0);
    chk("rst_right", {8'h0, right_sample}, 32'h0);
    chk("rst_left16", {16'h0, left_16}, 32'h0);
    chk("rst_locked", {31'h0, locked}, 32'h0);
    chk("rst_fv", {31'h0, frame_valid}, 32'h0);

    // Partial left slot before any boundary, then lock on the right slot.
    snap();
    send_slot(1'b0, 24'hFFFFFF, 10);
    repeat (8) @(negedge clk_100);
    chk("hunt_locked", {31'h0, locked}, 32'h0);
    send_slot(1'b1, 24'h123456, 32);
    chk("lock_locked", {31'h0, locked}, 32'h1);
    send_frame(24'hA5C3F0, 24'h123456, 32);
    send_frame(24'hA5C3F0, 24'h123456, 32);
    tail();
    chk("a_fv_cnt", fv_cnt - fv_base, 2);
    chk("a_se_cnt", se_cnt - se_base, 0);
    chk("a_left", {8'h0, left_sample}, 32'hA5C3F0);
    chk("a_right", {8'h0, right_sample}, 32'h123456);
    chk("a_left16", {16'h0, left_16}, 32'hA5C3);
    chk_pair("a_p0", fv_base, 24'hA5C3F0, 24'h123456);
    chk_pair("a_p1", fv_base + 1, 24'hA5C3F0, 24'h123456);

    // Three distinct frames.
    snap();
    send_frame(24'h000001, 24'hFFFFFF, 32);
    send_frame(24'h800000, 24'h7FFFFF, 32);
    send_frame(24'h555555, 24'hAAAAAA, 32);
    tail();
    chk("b_fv_cnt", fv_cnt - fv_base, 3);
    chk_pair("b_p0", fv_base, 24'h000001, 24'hFFFFFF);
    chk_pair("b_p1", fv_base + 1, 24'h800000, 24'h7FFFFF);
    chk_pair("b_p2", fv_base + 2, 24'h555555, 24'hAAAAAA);

    // Truncated left slot (20 bclk), then recovery.
    snap();
    send_slot(1'b0, 24'hDEADBE, 20);
    send_slot(1'b1, 24'h0BCDEF, 32);
    tail();
    chk("c_se_cnt", se_cnt - se_base, 1);
    chk("c_fv_cnt", fv_cnt - fv_base, 0);
    chk("c_left_kept", {8'h0, left_sample}, 32'h555555);
    chk("c_right", {8'h0, right_sample}, 32'h0BCDEF);
    snap();
    send_frame(24'h111111, 24'h222222, 32);
    tail();
    chk("c_rec_fv", fv_cnt - fv_base, 1);
    chk_pair("c_rec", fv_base, 24'h111111, 24'h222222);

    // 40-bit slots.
    snap();
    send_frame(24'hABCDEF, 24'h654321, 40);
    tail();
    chk("d_fv_cnt", fv_cnt - fv_base, 1);
    chk("d_se_cnt", se_cnt - se_base, 0);
    chk_pair("d_p0", fv_base, 24'hABCDEF, 24'h654321);

    // Reset at bit 10 of a right slot.
    send_slot(1'b0, 24'h13579B, 32);
    send_slot(1'b1, 24'h999999, 11);
    i2s_bclk = 1'b0;
    repeat (2) @(negedge clk_100);
    reset = 1'b1;
    repeat (5) @(negedge clk_100);
    reset = 1'b0;
    repeat (3) @(negedge clk_100);
    chk("e_left", {8'h0, left_sample}, 32'h0);
    chk("e_right", {8'h0, right_sample}, 32'h0);
    chk("e_left16", {16'h0, left_16}, 32'h0);
    chk("e_locked", {31'h0, locked}, 32'h0);
    snap();
    // lr is still 1 while lr_last cleared to 0: the next rise re-locks
    // mid-slot, so that right slot is short.
    send_slot(1'b1, 24'h999999, 21);
    chk("e_relock", {31'h0, locked}, 32'h1);
    send_slot(1'b0, 24'hC0FFEE, 32);
    repeat (8) @(negedge clk_100);
    chk("e_short", se_cnt - se_base, 1);
    chk("e_no_fv", fv_cnt - fv_base, 0);
    send_slot(1'b1, 24'h0FACED, 32);
    tail();
    chk("e_fv_cnt", fv_cnt - fv_base, 1);
    chk_pair("e_p0", fv_base, 24'hC0FFEE, 24'h0FACED);

    // bclk static for 10k cycles in the middle of the left slot.
    snap();
    stall_bit = 12;
    send_slot(1'b0, 24'h2468AC, 32);
    stall_bit = -1;
    chk("f_stall_fv", fv_cnt - fv_base, 0);
    chk("f_stall_se", se_cnt - se_base, 0);
    send_slot(1'b1, 24'hFDB975, 32);
    tail();
    chk("f_fv_cnt", fv_cnt - fv_base, 1);
    chk_pair("f_p0", fv_base, 24'h2468AC, 24'hFDB975);

    chk("overlap", {31'h0, overlap}, 32'h0);
    chk("pulse_width", {31'h0, wide}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
